// File: rtl/sudoku_board_checker.sv
// Verifies a solved sudoku board: row-by-row clue/range scan, then uniqueness scan of 27 rows/cols/boxes.
// Latency: 36 cycles capture-to-done on a full pass (27 without the clue scan), r+1 / base+u+1 on early exit.
// Backpressure: none; check_start is sampled only in IDLE, requests while busy are dropped (no queueing).
module sudoku_board_checker #(
    parameter bit CHECK_CLUES = 1'b1,
    parameter bit EARLY_EXIT  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         check_start,
    input  logic [0:323] sudoku_given,
    input  logic [0:323] sudoku_out,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [1:0]   fail_code,
    output logic [4:0]   fail_unit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLUE,
        S_UNIT,
        S_DONE
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [4:0]   idx_q;
    logic [4:0]   idx_d;
    logic [0:323] given_q;
    logic [0:323] out_q;

    logic [3:0]   cell_out   [81];
    logic [3:0]   cell_given [81];
    logic [6:0]   unit_ci    [9];
    logic [3:0]   unit_val   [9];
    logic [3:0]   unit_giv   [9];
    logic [8:0]   seen_mask;
    logic         range_ok;
    logic         clue_err;
    logic         unit_err;
    logic         err_now;
    logic         capture;

    // Cell i sits at bits [4i:4i+3]; bit 4i is the nibble MSB, so (0,0) is the leftmost hex digit.
    for (genvar i = 0; i < 81; i++) begin : g_cell
        assign cell_out[i]   = out_q[4*i +: 4];
        assign cell_given[i] = given_q[4*i +: 4];
    end

    // Map the current unit index to its nine cell positions (row, column or 3x3 box).
    // Rows 0..8 double as the clue-scan rows, so both phases share this selector.
    always_comb begin
        int b;
        b = 0;
        for (int k = 0; k < 9; k++) begin
            if (idx_q < 5'd9) begin
                unit_ci[k] = 7'(int'(idx_q) * 9 + k);
            end else if (idx_q < 5'd18) begin
                unit_ci[k] = 7'(k * 9 + int'(idx_q) - 9);
            end else begin
                b = (idx_q > 5'd26) ? 0 : int'(idx_q) - 18;
                unit_ci[k] = 7'(((b / 3) * 3 + k / 3) * 9 + (b % 3) * 3 + k % 3);
            end
            unit_val[k] = cell_out[unit_ci[k]];
            unit_giv[k] = cell_given[unit_ci[k]];
        end
    end

    // Evaluate the selected nine cells: seen-mask for uniqueness, range and clue agreement.
    always_comb begin
        seen_mask = '0;
        range_ok  = 1'b1;
        clue_err  = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (unit_val[k] >= 4'd1 && unit_val[k] <= 4'd9) begin
                seen_mask[unit_val[k] - 4'd1] = 1'b1;
            end else begin
                range_ok = 1'b0;
            end
            if (unit_giv[k] != 4'd0 && unit_giv[k] != unit_val[k]) begin
                clue_err = 1'b1;
            end
        end
        clue_err = clue_err || !range_ok;
        unit_err = !(range_ok && seen_mask == 9'h1FF);
    end

    assign err_now = (state_q == S_CLUE && clue_err) || (state_q == S_UNIT && unit_err);
    assign capture = (state_q == S_IDLE) && check_start;

    // State and phase index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state, index sequencing and status outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (check_start) begin
                    state_d = CHECK_CLUES ? S_CLUE : S_UNIT;
                    idx_d   = '0;
                end
            end
            S_CLUE: begin
                busy = 1'b1;
                if (EARLY_EXIT && err_now) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else if (idx_q == 5'd8) begin
                    state_d = S_UNIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_UNIT: begin
                busy = 1'b1;
                if ((EARLY_EXIT && err_now) || idx_q == 5'd26) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Board capture, first-failure recording and the held pass/fail result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            given_q   <= '0;
            out_q     <= '0;
            valid     <= 1'b0;
            fail_code <= 2'd0;
            fail_unit <= 5'd0;
        end else begin
            if (capture) begin
                given_q   <= sudoku_given;
                out_q     <= sudoku_out;
                valid     <= 1'b0;
                fail_code <= 2'd0;
                fail_unit <= 5'd0;
            end else if (err_now && fail_code == 2'd0) begin
                fail_code <= (state_q == S_CLUE) ? 2'd1 : 2'd2;
                fail_unit <= idx_q;
            end
            // The result becomes visible together with the done pulse.
            if (state_d == S_DONE && state_q != S_DONE) begin
                valid <= (fail_code == 2'd0) && !err_now;
            end
        end
    end

endmodule

// File: tb/tb_sudoku_board_checker.sv
module tb_sudoku_board_checker;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         check_start = 1'b0;
    logic [0:323] b_given = '0;
    logic [0:323] b_out = '0;

    // Instance 0: CHECK_CLUES=1 EARLY_EXIT=1; 1: clues, no early exit; 2: no clue phase, early exit.
    logic [2:0]      busy_w;
    logic [2:0]      done_w;
    logic [2:0]      valid_w;
    logic [2:0][1:0] code_w;
    logic [2:0][4:0] unit_w;

    int passes = 0;
    int checks = 0;

    int         obs_first  [3];
    int         obs_second [3];
    int         obs_pulses [3];
    logic       obs_valid  [3];
    logic [1:0] obs_code   [3];
    logic [4:0] obs_unit   [3];
    logic       obs_hold   [3];
    int         busy_hi;
    logic       busy_end;

    always #5 clk = ~clk;

    sudoku_board_checker #(.CHECK_CLUES(1'b1), .EARLY_EXIT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .check_start(check_start), .sudoku_given(b_given), .sudoku_out(b_out),
        .busy(busy_w[0]), .done(done_w[0]), .valid(valid_w[0]), .fail_code(code_w[0]), .fail_unit(unit_w[0]));
    sudoku_board_checker #(.CHECK_CLUES(1'b1), .EARLY_EXIT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .check_start(check_start), .sudoku_given(b_given), .sudoku_out(b_out),
        .busy(busy_w[1]), .done(done_w[1]), .valid(valid_w[1]), .fail_code(code_w[1]), .fail_unit(unit_w[1]));
    sudoku_board_checker #(.CHECK_CLUES(1'b0), .EARLY_EXIT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .check_start(check_start), .sudoku_given(b_given), .sudoku_out(b_out),
        .busy(busy_w[2]), .done(done_w[2]), .valid(valid_w[2]), .fail_code(code_w[2]), .fail_unit(unit_w[2]));

    function automatic int cell_of(input logic [0:323] b, input int r, input int c);
        logic [3:0] v;
        v = b[4*(r*9+c) +: 4];
        return int'(v);
    endfunction

    function automatic logic [0:323] with_cell(input logic [0:323] b, input int r, input int c, input int v);
        logic [0:323] t;
        t = b;
        t[4*(r*9+c) +: 4] = 4'(v);
        return t;
    endfunction

    // Pattern board P with digit d replaced by p[d-1].
    function automatic logic [0:323] make_board(input int p [9]);
        logic [0:323] t;
        t = '0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                t = with_cell(t, r, c, p[(r*3 + r/3 + c) % 9]);
        return t;
    endfunction

    function automatic logic [0:323] pattern_p();
        int p [9];
        for (int i = 0; i < 9; i++) p[i] = i + 1;
        return make_board(p);
    endfunction

    // Reference: sudoku rules evaluated with digit counting; latency from the phase schedule.
    function automatic void model(input int k, input logic [0:323] o, input logic [0:323] g,
                                  output int code, output int unit, output int lat);
        bit use_clues, early;
        int cnt [10];
        int r, c, v, gv;
        bit bad;
        use_clues = (k != 2);
        early     = (k != 1);
        code = 0;
        unit = 0;
        if (use_clues) begin
            for (int rr = 0; rr < 9; rr++)
                for (int cc = 0; cc < 9; cc++) begin
                    v  = cell_of(o, rr, cc);
                    gv = cell_of(g, rr, cc);
                    if ((v < 1 || v > 9 || (gv != 0 && gv != v)) && code == 0) begin
                        code = 1;
                        unit = rr;
                    end
                end
        end
        for (int u = 0; u < 27; u++) begin
            cnt = '{default: 0};
            for (int j = 0; j < 9; j++) begin
                if (u < 9) begin r = u; c = j; end
                else if (u < 18) begin r = j; c = u - 9; end
                else begin r = ((u - 18) / 3) * 3 + j / 3; c = ((u - 18) % 3) * 3 + j % 3; end
                v = cell_of(o, r, c);
                cnt[(v > 9) ? 0 : v]++;
            end
            bad = (cnt[0] != 0);
            for (int d = 1; d <= 9; d++) if (cnt[d] != 1) bad = 1'b1;
            if (bad && code == 0) begin
                code = 2;
                unit = u;
            end
        end
        if (early && code == 1)      lat = unit + 1;
        else if (early && code == 2) lat = (use_clues ? 9 : 0) + unit + 1;
        else                         lat = use_clues ? 36 : 27;
    endfunction

    // Launch one check and record what each instance does over a bounded window of cycles.
    task automatic run_check(input int window, input bit disturb, input bit hold);
        for (int k = 0; k < 3; k++) begin
            obs_first[k] = -1; obs_second[k] = -1; obs_pulses[k] = 0;
            obs_valid[k] = 1'bx; obs_code[k] = 'x; obs_unit[k] = 'x; obs_hold[k] = 1'b0;
        end
        busy_hi = 0;
        busy_end = 1'bx;
        @(posedge clk); #1;
        check_start = 1'b1;
        @(posedge clk); #1;
        check_start = hold;
        for (int n = 1; n <= window; n++) begin
            if (disturb) begin
                if (n == 2) b_out = '0;
                check_start = (n == 5 || n == 6 || n == 20);
            end
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (done_w[k] === 1'b1) begin
                    obs_pulses[k]++;
                    if (obs_first[k] < 0) begin
                        obs_first[k] = n;
                        obs_valid[k] = valid_w[k];
                        obs_code[k]  = code_w[k];
                        obs_unit[k]  = unit_w[k];
                    end else if (obs_second[k] < 0) begin
                        obs_second[k] = n;
                    end
                end
            end
            if (n <= 35 && busy_w[0] === 1'b1) busy_hi++;
            if (n == 36) busy_end = busy_w[0];
        end
        check_start = 1'b0;
        for (int k = 0; k < 3; k++)
            obs_hold[k] = (valid_w[k] === obs_valid[k]) && (code_w[k] === obs_code[k]) && (unit_w[k] === obs_unit[k]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_w[k], done_w[k], valid_w[k], code_w[k], unit_w[k]} !== 10'd0)
                $display("FAIL reset_state dut%0d: got busy=%b done=%b valid=%b code=%0d unit=%0d, want all 0",
                         k, busy_w[k], done_w[k], valid_w[k], code_w[k], unit_w[k]);
            else passes++;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        int tab_code [4];
        int tab_unit [4];
        int tab_lat  [4];
        int ec, eu, el;
        logic [0:323] p;
        tab_code = '{0, 1, 2, 1};
        tab_unit = '{0, 0, 9, 7};
        tab_lat  = '{36, 1, 19, 8};
        p = pattern_p();
        for (int t = 0; t < 4; t++) begin
            case (t)
                0: begin b_out = p; b_given = '0; end
                1: begin b_out = p; b_given = with_cell(p, 0, 0, 5); end
                2: begin b_out = with_cell(with_cell(p, 4, 0, 6), 4, 1, 5); b_given = '0; end
                default: begin b_out = with_cell(p, 7, 3, 0); b_given = '0; end
            endcase
            run_check(45, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                if (k == 2) model(2, b_out, b_given, ec, eu, el);
                else begin ec = tab_code[t]; eu = tab_unit[t]; el = (k == 1) ? 36 : tab_lat[t]; end
                checks++;
                if (obs_first[k] !== el || obs_pulses[k] !== 1)
                    $display("FAIL directed%0d_done dut%0d: got cycle %0d pulses %0d, want cycle %0d pulses 1",
                             t, k, obs_first[k], obs_pulses[k], el);
                else passes++;
                checks++;
                if (obs_valid[k] !== (ec == 0) || obs_code[k] !== 2'(ec) || obs_unit[k] !== 5'(eu))
                    $display("FAIL directed%0d_result dut%0d: got valid=%b code=%0d unit=%0d, want valid=%b code=%0d unit=%0d",
                             t, k, obs_valid[k], obs_code[k], obs_unit[k], ec == 0, ec, eu);
                else passes++;
                checks++;
                if (!obs_hold[k]) $display("FAIL directed%0d_hold dut%0d: result changed after done", t, k);
                else passes++;
            end
            if (t == 0) begin
                checks++;
                if (busy_hi !== 35 || busy_end !== 1'b0)
                    $display("FAIL busy_window dut0: got %0d busy cycles in 1..35, busy@36=%b, want 35 and 0",
                             busy_hi, busy_end);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int ec, eu, el;
        logic [0:323] p;
        p = pattern_p();
        b_out = p;
        b_given = '0;
        @(posedge clk); #1;
        check_start = 1'b1;
        @(posedge clk); #1;
        check_start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (busy_w !== 3'b111) $display("FAIL midreset_busy_before: got %b, want 111", busy_w);
        else passes++;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy_w[k], done_w[k], valid_w[k], code_w[k], unit_w[k]} !== 10'd0)
                $display("FAIL midreset_outputs dut%0d: got busy=%b done=%b valid=%b code=%0d unit=%0d, want all 0",
                         k, busy_w[k], done_w[k], valid_w[k], code_w[k], unit_w[k]);
            else passes++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done_w !== 3'b000) $display("FAIL midreset_no_done: got %b, want 000", done_w);
        else passes++;
        rst = 1'b1;
        run_check(45, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            model(k, b_out, b_given, ec, eu, el);
            checks++;
            if (obs_first[k] !== el || obs_valid[k] !== 1'b1)
                $display("FAIL midreset_recheck dut%0d: got done cycle %0d valid=%b, want cycle %0d valid=1",
                         k, obs_first[k], obs_valid[k], el);
            else passes++;
        end
    endtask

    task automatic test_ignore_start_and_overwrite();
        int ec, eu, el;
        b_out = pattern_p();
        b_given = '0;
        run_check(45, 1'b1, 1'b0);
        model(0, pattern_p(), '0, ec, eu, el);
        for (int k = 0; k < 3; k++) begin
            model(k, pattern_p(), '0, ec, eu, el);
            checks++;
            if (obs_pulses[k] !== 1 || obs_first[k] !== el || obs_valid[k] !== 1'b1 || obs_code[k] !== 2'd0)
                $display("FAIL overwrite dut%0d: got pulses %0d cycle %0d valid=%b code=%0d, want 1 pulse cycle %0d valid=1 code=0",
                         k, obs_pulses[k], obs_first[k], obs_valid[k], obs_code[k], el);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        int ec, eu, el;
        b_out = pattern_p();
        b_given = '0;
        run_check(80, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            model(k, b_out, b_given, ec, eu, el);
            checks++;
            if (obs_first[k] !== el || obs_second[k] !== 2 * el + 2)
                $display("FAIL back_to_back dut%0d: got done at %0d and %0d, want %0d and %0d",
                         k, obs_first[k], obs_second[k], el, 2 * el + 2);
            else passes++;
        end
        repeat (50) @(posedge clk);
    endtask

    task automatic test_random();
        int p [9];
        int j, tmp, mode, ec, eu, el, r, c, v;
        logic [0:323] base;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 9; i++) p[i] = i + 1;
            for (int i = 8; i > 0; i--) begin
                j = int'($urandom_range(0, i));
                tmp = p[i]; p[i] = p[j]; p[j] = tmp;
            end
            base = make_board(p);
            b_out = base;
            b_given = '0;
            for (int i = 0; i < 81; i++)
                if ($urandom_range(0, 9) < 3) b_given = with_cell(b_given, i / 9, i % 9, cell_of(base, i / 9, i % 9));
            mode = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 8));
            c = int'($urandom_range(0, 8));
            case (mode)
                1: b_out = with_cell(b_out, r, c, int'($urandom_range(0, 15)));
                2: begin
                    j = int'($urandom_range(0, 8));
                    v = cell_of(b_out, r, c);
                    b_out = with_cell(b_out, r, c, cell_of(b_out, r, j));
                    b_out = with_cell(b_out, r, j, v);
                end
                3: b_given = with_cell(b_given, r, c, (cell_of(base, r, c) % 9) + 1);
                default: ;
            endcase
            run_check(45, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                model(k, b_out, b_given, ec, eu, el);
                checks++;
                if (obs_first[k] !== el || obs_pulses[k] !== 1 || obs_valid[k] !== (ec == 0) ||
                    obs_code[k] !== 2'(ec) || obs_unit[k] !== 5'(eu))
                    $display("FAIL random%0d dut%0d: got cycle %0d pulses %0d valid=%b code=%0d unit=%0d, want cycle %0d valid=%b code=%0d unit=%0d",
                             it, k, obs_first[k], obs_pulses[k], obs_valid[k], obs_code[k], obs_unit[k],
                             el, ec == 0, ec, eu);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_ignore_start_and_overwrite();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
